// File: rtl/softcore_top_pio_seq_pkg.sv
// Shared constants for the sequenced PIO: register map, CTRL/STATUS bit
// positions and the sequencer state type.
package softcore_top_pio_seq_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_PUSH   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int CNT_FIELD_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/softcore_top_pio_seq_fifo.sv
// Pattern FIFO: power-of-two depth, simultaneous push/pop allowed when full,
// synchronous flush that wins over push and pop.
module softcore_top_pio_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers gate its validity,
  // and a reset-free array maps onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/softcore_top_pio_seq.sv
// Avalon-MM PIO that plays a queue of {hold, pattern} entries on out_port.
// Optional pattern recirculation is enabled by defining PIO_SEQ_LOOP_EN.
module softcore_top_pio_seq
  import softcore_top_pio_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        busy
);

  localparam int EW = 8 + HOLD_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [7:0]        out_q, out_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ovf_q, ovf_d;
  logic              loop_q;
`ifdef PIO_SEQ_LOOP_EN
  logic              loop_d;
`endif

  logic              wr_en, wr_data, wr_push, wr_ctrl, wr_status;
  logic [HOLD_W-1:0] hold_in;
  logic [EW-1:0]     cpu_entry;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic [EW-1:0]     fifo_din, fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              reload, drop, push_blocked, busy_w;
  logic              unused_wdata;

  assign wr_en     = chipselect && !write_n;
  assign wr_data   = wr_en && (address == ADDR_DATA);
  assign wr_push   = wr_en && (address == ADDR_PUSH);
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_status = wr_en && (address == ADDR_STATUS);
  assign busy_w    = (state_q != S_IDLE);
  assign busy      = busy_w;
  assign out_port  = out_q;

  // Hold 0 is stored as 1 so the sequencer never sees a zero-length entry.
  assign hold_in   = writedata[8 +: HOLD_W];
  assign cpu_entry = {(hold_in == '0) ? HOLD_W'(1) : hold_in, writedata[7:0]};
  assign unused_wdata = &{1'b0, writedata};

`ifdef PIO_SEQ_LOOP_EN
  assign push_blocked = busy_w && loop_q;
`else
  assign loop_q       = 1'b0;
  assign push_blocked = 1'b0;
`endif

  softcore_top_pio_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    hold_d     = hold_q;
    ovf_d      = ovf_q;
`ifdef PIO_SEQ_LOOP_EN
    loop_d     = loop_q;
`endif
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    fifo_din   = cpu_entry;
    reload     = 1'b0;
    drop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wr_data) out_d = writedata[7:0];
        if (wr_ctrl && writedata[CTRL_START] && !fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: reload = 1'b1;
      S_HOLD: begin
        // Back-to-back entries reload straight from HOLD so there is no gap.
        if (hold_q == '0) begin
          if (!fifo_empty) reload = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      fifo_pop = 1'b1;
      out_d    = fifo_dout[7:0];
      hold_d   = fifo_dout[8 +: HOLD_W] - HOLD_W'(1);
      state_d  = S_HOLD;
`ifdef PIO_SEQ_LOOP_EN
      if (loop_q) begin
        fifo_push = 1'b1;
        fifo_din  = fifo_dout;
      end
`endif
    end

    if (wr_push) begin
      if (push_blocked) begin
        drop = 1'b1;
      end else begin
        fifo_push = 1'b1;
        fifo_din  = cpu_entry;
        drop      = fifo_full && !fifo_pop;
      end
    end

    if (wr_status && writedata[ST_OVF]) ovf_d = 1'b0;
    if (drop)                           ovf_d = 1'b1;

    if (wr_ctrl) begin
`ifdef PIO_SEQ_LOOP_EN
      loop_d = writedata[CTRL_LOOP];
`endif
      if (writedata[CTRL_STOP]) begin
        state_d    = S_IDLE;
        out_d      = out_q;
        hold_d     = '0;
        fifo_flush = 1'b1;
        fifo_pop   = 1'b0;
        fifo_push  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PIO_SEQ_LOOP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) loop_q <= 1'b0;
    else       loop_q <= loop_d;
  end
`endif

  // Read mux is purely combinational on address; chipselect is not required.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA: readdata[7:0] = out_q;
      ADDR_CTRL: readdata[CTRL_LOOP] = loop_q;
      ADDR_STATUS: begin
        readdata[ST_BUSY]  = busy_w;
        readdata[ST_EMPTY] = fifo_empty;
        readdata[ST_FULL]  = fifo_full;
        readdata[ST_OVF]   = ovf_q;
        readdata[ST_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(fifo_count);
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_softcore_top_pio_seq.sv
// Self-checking bench: register vector table, timed sequence corners and
// randomized queues checked against an expanded-trace reference model.
module tb_softcore_top_pio_seq;

  localparam int DEPTH  = 8;
  localparam int HOLD_W = 16;
  localparam logic [1:0] A_DATA = 2'd0, A_PUSH = 2'd1, A_CTRL = 2'd2, A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned hold;
    logic [7:0]  pat;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] rexp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  softcore_top_pio_seq #(.FIFO_DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one write cycle and returns at the next negedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] e, input string nm);
    address = a;
    #1;
    check(nm, readdata, e);
  endtask

  task automatic push(input int unsigned h, input logic [7:0] p);
    bus_write(A_PUSH, (h << 8) | 32'(p));
  endtask

  function automatic logic [31:0] status_word(input bit b, input int cnt, input bit ovf);
    return (32'(cnt) << 4) | (32'(ovf) << 3) | (32'(cnt == DEPTH) << 2) | (32'(cnt == 0) << 1) | 32'(b);
  endfunction

  // Caller is at the negedge where the sequencer sits in LOAD.
  // Model: every entry appears for max(hold,1) cycles back to back, then idle.
  task automatic trace(input string nm);
    logic [7:0] last;
    last = out_port;
    check({nm, "_load_busy"}, 32'(busy), 32'd1);
    foreach (q[i]) begin
      for (int c = 0; c < ((q[i].hold == 0) ? 1 : q[i].hold); c++) begin
        @(negedge clk);
        check({nm, "_out"}, 32'(out_port), 32'(q[i].pat));
        check({nm, "_busy"}, 32'(busy), 32'd1);
        last = q[i].pat;
      end
    end
    @(negedge clk);
    check({nm, "_done_busy"}, 32'(busy), 32'd0);
    check({nm, "_done_out"}, 32'(out_port), 32'(last));
  endtask

  initial begin
    logic [7:0]  lastp;
    logic [31:0] d;
    int          n, cnt;
    bit          ovf;

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_out", 32'(out_port), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd_check(A_STAT, 32'h2, "rst_status");
    rd_check(A_DATA, 32'h0, "rst_data");
    @(negedge clk);

    // Register-level vectors: write, then read back a register.
    vecs[0] = '{A_DATA, 32'h0000_00A5, A_DATA, 32'h0000_00A5, "data_a5"};
    vecs[1] = '{A_DATA, 32'h0000_01FF, A_DATA, 32'h0000_00FF, "data_trunc"};
`ifdef PIO_SEQ_LOOP_EN
    vecs[2] = '{A_CTRL, 32'h0000_0004, A_CTRL, 32'h0000_0004, "ctrl_loop_rd"};
`else
    vecs[2] = '{A_CTRL, 32'h0000_0004, A_CTRL, 32'h0000_0000, "ctrl_loop_rd"};
`endif
    vecs[3] = '{A_CTRL, 32'h0000_0001, A_STAT, 32'h0000_0002, "start_empty"};
    vecs[4] = '{A_PUSH, 32'h0000_0311, A_STAT, 32'h0000_0010, "push1"};
    vecs[5] = '{A_PUSH, 32'h0000_0055, A_STAT, 32'h0000_0020, "push2"};
    vecs[6] = '{A_CTRL, 32'h0000_0002, A_STAT, 32'h0000_0002, "stop_flush"};
    vecs[7] = '{A_STAT, 32'h0000_0008, A_STAT, 32'h0000_0002, "w1c_idle"};
    foreach (vecs[i]) begin
      bus_write(vecs[i].wa, vecs[i].wd);
      rd_check(vecs[i].ra, vecs[i].rexp, vecs[i].name);
      @(negedge clk);
    end

    // Two-entry sequence, then DATA writes work again.
    q.delete();
    q.push_back('{3, 8'h11}); q.push_back('{2, 8'h22});
    foreach (q[i]) push(q[i].hold, q[i].pat);
    bus_write(A_CTRL, 32'h1);
    check("seq2_load_out_unchanged", 32'(out_port), 32'h0000_00FF);
    trace("seq2");
    bus_write(A_DATA, 32'h3C);
    check("data_after_seq", 32'(out_port), 32'h3C);

    // Nine pushes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) push(1, 8'(i));
    rd_check(A_STAT, 32'h0000_008C, "ovf_full");
    @(negedge clk);
    bus_write(A_STAT, 32'h8);
    rd_check(A_STAT, 32'h0000_0084, "ovf_w1c");
    @(negedge clk);
    bus_write(A_CTRL, 32'h2);
    rd_check(A_STAT, 32'h0000_0002, "flush_after_ovf");
    @(negedge clk);

    // Full FIFO: PUSH in the LOAD cycle coincides with the pop and succeeds.
    for (int i = 0; i < DEPTH; i++) push(1, 8'(8'hB0 + i));
    bus_write(A_CTRL, 32'h1);
    bus_write(A_PUSH, 32'h0000_01C0);
    check("fullpp_out0", 32'(out_port), 32'hB0);
    rd_check(A_STAT, 32'h0000_0085, "fullpp_status");
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      check("fullpp_out", 32'(out_port), (i < DEPTH) ? 32'(8'hB0 + i) : 32'hC0);
    end
    @(negedge clk);
    check("fullpp_done", 32'(busy), 32'd0);

    // DATA ignored while busy; STOP+START together stops and flushes.
    push(5, 8'h40); push(5, 8'h41);
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    bus_write(A_DATA, 32'h99);
    check("data_ignored_busy", 32'(out_port), 32'h40);
    @(negedge clk);
    lastp = out_port;
    bus_write(A_CTRL, 32'h3);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_out_kept", 32'(out_port), 32'(lastp));
    rd_check(A_STAT, 32'h0000_0002, "stop_status");
    @(negedge clk);

    // Reset in the middle of a long hold.
    push(100, 8'h77);
    bus_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    check("pre_reset_out", 32'(out_port), 32'h77);
    reset = 1'b1;
    #1;
    check("midrst_out", 32'(out_port), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rd_check(A_STAT, 32'h0000_0002, "midrst_status");
    @(negedge clk);
    reset = 1'b0;
    bus_write(A_CTRL, 32'h1);
    check("start_after_rst", 32'(busy), 32'd0);

    // Randomized queues against the trace model.
    for (int it = 0; it < 16; it++) begin
      d = $urandom;
      bus_write(A_DATA, d);
      check("rnd_data", 32'(out_port), 32'(d[7:0]));
      q.delete();
      ovf = 1'b0;
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        ent_t e;
        e.hold = $urandom_range(0, 4);
        e.pat  = 8'($urandom);
        push(e.hold, e.pat);
        if (q.size() < DEPTH) q.push_back(e);
        else                  ovf = 1'b1;
      end
      cnt = q.size();
      rd_check(A_STAT, status_word(1'b0, cnt, ovf), "rnd_status");
      @(negedge clk);
      bus_write(A_CTRL, 32'h1);
      trace("rnd");
      rd_check(A_STAT, status_word(1'b0, 0, ovf), "rnd_status_done");
      @(negedge clk);
      bus_write(A_STAT, 32'h8);
    end

`ifdef PIO_SEQ_LOOP_EN
    // Looping two single-cycle entries; PUSH while looping is dropped.
    bus_write(A_CTRL, 32'h4);
    push(1, 8'h01); push(1, 8'h02);
    bus_write(A_CTRL, 32'h5);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 8) begin
        address = A_PUSH; writedata = 32'h0000_0133; chipselect = 1'b1; write_n = 1'b0;
      end
      if (i == 9) begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      check("loop_out", 32'(out_port), (i % 2 == 0) ? 32'h01 : 32'h02);
    end
    rd_check(A_STAT, 32'h0000_0029, "loop_ovf");
    @(negedge clk);
    bus_write(A_CTRL, 32'h2);
    rd_check(A_STAT, 32'h0000_000A, "loop_stop");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/softcore_top_pio_seq.md
SOFTCORE_TOP_PIO_SEQ -- requirements
Module: softcore_top_pio_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, pattern FIFO entries (power of two, 2..16).
REQ-002 Parameter HOLD_W, default 16, width of the per-entry hold counter.
REQ-003 The block SHALL have these ports: clk, input, 1, sole clock.
REQ-004 reset, input, 1, asynchronous active-high reset.
REQ-005 address, input, 2, Avalon-MM register select.
REQ-006 chipselect, input, 1, slave select.
REQ-007 write_n, input, 1, active-low write strobe.
REQ-008 writedata, input, 32, write data.
REQ-009 readdata, output, 32, combinational read mux, unused bits zero.
REQ-010 out_port, output, 8, sequenced PIO output.
REQ-011 busy, output, 1, high while the FSM is not IDLE.

Function
REQ-012 Write access SHALL be defined as chipselect && !write_n; register map: 0 DATA, 1 PUSH, 2 CTRL, 3 STATUS.
REQ-013 DATA write in IDLE SHALL set out_port <= writedata[7:0] next edge; DATA write while busy SHALL be ignored; DATA read returns {24'b0, out_port}.
REQ-014 PUSH write SHALL enqueue {writedata[8+HOLD_W-1:8], writedata[7:0]}; hold value 0 is treated as 1.
REQ-015 PUSH when FIFO full and no pop in the same cycle SHALL be dropped and set sticky OVF; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-016 CTRL write bit0 START: IDLE with count > 0 -> LOAD; START with empty FIFO or while busy SHALL be ignored.
REQ-017 CTRL write bit1 STOP SHALL take priority over START: FSM -> IDLE next edge, FIFO flushed, out_port keeps last value.
REQ-018 FSM states IDLE, LOAD, HOLD; LOAD pops the head, sets out_port <= pattern and hold counter <= hold-1, goes to HOLD.
REQ-019 HOLD decrements the counter each cycle; at 0 -> LOAD if count > 0, else IDLE.
REQ-020 Latency: START written at edge n -> LOAD at n+1 -> out_port shows entry 0 after edge n+2; each entry is driven for exactly hold cycles, with no gap between entries.
REQ-021 STATUS read SHALL return bit0 busy, bit1 empty, bit2 full, bit3 OVF, bits[8:4] count; writing 1 to bit3 SHALL clear OVF (W1C).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.

Reset
REQ-023 On reset, out_port = 0, FSM = IDLE, busy = 0, FIFO empty (count 0, pointers 0), OVF = 0, hold counter = 0, LOOP = 0.
REQ-024 Reset asserted mid-sequence SHALL abort immediately; no entry survives reset.

Configuration
REQ-025 With PIO_SEQ_LOOP_EN defined, CTRL bit2 SHALL be the read/write LOOP flag: in LOAD each popped entry is re-pushed to the tail in the same cycle, so the sequence repeats until STOP; CPU PUSH while busy and LOOP=1 SHALL be dropped and set OVF.
REQ-026 Without PIO_SEQ_LOOP_EN, CTRL bit2 SHALL be ignored and read as 0; there is no recirculation logic.

Structure
REQ-027 Package softcore_top_pio_seq_pkg SHALL hold the register address constants, CTRL/STATUS bit indices and the FSM state typedef.
REQ-028 The FIFO SHALL be a sub-module softcore_top_pio_seq_fifo (push, pop, full, empty, count, flush).

Verification
REQ-029 Reset, then DATA write 0xA5 -> out_port = 0xA5 next cycle; readdata at address 0 = 0x000000A5.
REQ-030 PUSH {hold 3, 0x11}, {hold 2, 0x22}, START -> out_port 0x11 for 3 cycles, then 0x22 for 2 cycles; busy drops, then DATA writes take effect again.
REQ-031 Nine PUSHes with FIFO_DEPTH=8 while IDLE -> STATUS full=1, OVF=1, count=8; W1C of bit3 -> OVF=0.
REQ-032 Sequence running, STOP and START written together -> IDLE next edge, FIFO empty, out_port holds last pattern.
REQ-033 Assert reset during HOLD of a hold-100 entry -> out_port = 0, busy = 0, count = 0 immediately.
REQ-034 With PIO_SEQ_LOOP_EN, LOOP=1, entries {hold 1, 0x01}, {hold 1, 0x02} -> out_port alternates 01/02 indefinitely; PUSH while busy sets OVF.
